// File: rtl/raster_to_block.sv
// raster_to_block: reorders a raster-order pixel stream into 8x8 block order.
//
// Two stripe banks (8 lines each) are used ping-pong: the write side fills one
// bank in raster order while the read side drains the other bank block by
// block (left to right, row-major inside each block).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_axis_*          raster input (tuser = start of frame, tlast = end of line)
//   m_axis_*          block-ordered output (tlast = last pixel of an 8x8 block,
//                     tuser = first pixel of a stripe that began with SOF)
//   sync_err          sticky framing error, cleared only by reset
module raster_to_block #(
    parameter int unsigned IMG_WIDTH = 64,
    parameter int unsigned DATA_W    = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              sync_err
);

    localparam int unsigned STRIPE = 8 * IMG_WIDTH;
    localparam int unsigned DEPTH  = 2 * STRIPE;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
    localparam int unsigned BLKS   = IMG_WIDTH / 8;
    localparam int unsigned BLK_W  = (BLKS > 1) ? $clog2(BLKS) : 1;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RUN  = 1'b1
    } rd_state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [COL_W-1:0] wr_col;
    logic [2:0]       wr_row;
    logic             wr_bank;
    logic [1:0]       full;
    logic [1:0]       sof;

    logic             accept;
    logic             at_origin;
    logic             restart;
    logic             col_end;
    logic             line_end;
    logic             stripe_done;
    logic [AW-1:0]    wr_base;
    logic [AW-1:0]    wr_addr;

    // Bank release, driven by the output stage
    logic             free;
    logic             free_bank;

    assign s_axis_tready = !full[wr_bank];
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign at_origin     = (wr_row == 3'd0) && (wr_col == COL_W'(0));
    // SOF away from the stripe origin discards the partial stripe
    assign restart       = accept && s_axis_tuser && !at_origin;
    assign col_end       = (wr_col == COL_W'(IMG_WIDTH - 1));
    // Column the accepted pixel actually lands in decides where tlast belongs
    assign line_end      = restart ? 1'b0 : col_end;
    assign stripe_done   = accept && !restart && (wr_row == 3'd7) && col_end;

    assign wr_base = wr_bank ? AW'(STRIPE) : AW'(0);
    assign wr_addr = restart ? wr_base
                             : wr_base + AW'(wr_row) * AW'(IMG_WIDTH) + AW'(wr_col);

    // Pixel write into the bank being filled
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= s_axis_tdata;
        end
    end

    // Raster position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_col  <= '0;
            wr_row  <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            if (restart) begin
                wr_row <= 3'd0;
                wr_col <= COL_W'(1);
            end else if (stripe_done) begin
                wr_row  <= 3'd0;
                wr_col  <= '0;
                wr_bank <= ~wr_bank;
            end else if (col_end) begin
                wr_col <= '0;
                wr_row <= wr_row + 3'd1;
            end else begin
                wr_col <= wr_col + COL_W'(1);
            end
        end
    end

    // Sticky framing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
        end else if (accept && (restart || (s_axis_tlast != line_end))) begin
            sync_err <= 1'b1;
        end
    end

    // Bank flags: set by the writer, released by the output stage.
    // The writer only touches a non-full bank and only a full bank is
    // released, so the two never collide on the same bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            sof  <= '0;
        end else begin
            if (stripe_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (accept && s_axis_tuser) begin
                sof[wr_bank] <= 1'b1;
            end
            if (free) begin
                full[free_bank] <= 1'b0;
                sof[free_bank]  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side FSM
    // ------------------------------------------------------------------
    rd_state_t        state_q;
    rd_state_t        state_d;
    logic [BLK_W-1:0] rd_blk_q;
    logic [BLK_W-1:0] rd_blk_d;
    logic [2:0]       rd_row_q;
    logic [2:0]       rd_row_d;
    logic [2:0]       rd_col_q;
    logic [2:0]       rd_col_d;
    logic             rd_bank_q;
    logic             rd_bank_d;

    logic             rd_issue;
    logic             room;
    logic             px_last;
    logic             px_user;
    logic             px_done;
    logic [AW-1:0]    rd_addr;

    // Output stage
    logic              out_done;
    logic              out_bank;
    logic              sk_valid;
    logic [DATA_W-1:0] sk_data;
    logic              sk_last;
    logic              sk_user;
    logic              sk_done;
    logic              sk_bank;

    // A read may be issued whenever the two-entry output stage will have a
    // free slot at the next edge
    assign room = !sk_valid || m_axis_tready;

    assign px_last = (rd_row_q == 3'd7) && (rd_col_q == 3'd7);
    assign px_user = sof[rd_bank_q] && (rd_blk_q == BLK_W'(0))
                     && (rd_row_q == 3'd0) && (rd_col_q == 3'd0);
    assign px_done = px_last && (rd_blk_q == BLK_W'(BLKS - 1));

    assign rd_addr = (rd_bank_q ? AW'(STRIPE) : AW'(0))
                     + AW'(rd_row_q) * AW'(IMG_WIDTH)
                     + (AW'(rd_blk_q) << 3)
                     + AW'(rd_col_q);

    // FSM state and block counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= R_IDLE;
            rd_blk_q  <= '0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_blk_q  <= rd_blk_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Next-state: walk col -> row -> blk, hop banks after the final pixel
    always_comb begin
        state_d   = state_q;
        rd_blk_d  = rd_blk_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        rd_bank_d = rd_bank_q;
        rd_issue  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (full[rd_bank_q]) begin
                    state_d  = R_RUN;
                    rd_blk_d = '0;
                    rd_row_d = '0;
                    rd_col_d = '0;
                end
            end
            R_RUN: begin
                if (room) begin
                    rd_issue = 1'b1;
                    if (rd_col_q == 3'd7) begin
                        rd_col_d = 3'd0;
                        if (rd_row_q == 3'd7) begin
                            rd_row_d = 3'd0;
                            if (rd_blk_q == BLK_W'(BLKS - 1)) begin
                                rd_blk_d  = '0;
                                rd_bank_d = ~rd_bank_q;
                                state_d   = R_IDLE;
                            end else begin
                                rd_blk_d = rd_blk_q + BLK_W'(1);
                            end
                        end else begin
                            rd_row_d = rd_row_q + 3'd1;
                        end
                    end else begin
                        rd_col_d = rd_col_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage: head register plus one skid entry. RAM reads land
    // directly in whichever entry is free at the edge.
    // ------------------------------------------------------------------
    // A bank is released only once its final pixel leaves the output port,
    // so the writer can never overwrite data that is still queued here.
    assign free      = m_axis_tvalid && m_axis_tready && out_done;
    assign free_bank = out_bank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            out_done      <= 1'b0;
            out_bank      <= 1'b0;
            sk_valid      <= 1'b0;
            sk_data       <= '0;
            sk_last       <= 1'b0;
            sk_user       <= 1'b0;
            sk_done       <= 1'b0;
            sk_bank       <= 1'b0;
        end else if (!m_axis_tvalid || m_axis_tready) begin
            if (sk_valid) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sk_data;
                m_axis_tlast  <= sk_last;
                m_axis_tuser  <= sk_user;
                out_done      <= sk_done;
                out_bank      <= sk_bank;
                sk_valid      <= rd_issue;
                if (rd_issue) begin
                    sk_data <= mem[rd_addr];
                    sk_last <= px_last;
                    sk_user <= px_user;
                    sk_done <= px_done;
                    sk_bank <= rd_bank_q;
                end
            end else begin
                m_axis_tvalid <= rd_issue;
                if (rd_issue) begin
                    m_axis_tdata <= mem[rd_addr];
                    m_axis_tlast <= px_last;
                    m_axis_tuser <= px_user;
                    out_done     <= px_done;
                    out_bank     <= rd_bank_q;
                end
            end
        end else if (rd_issue) begin
            sk_valid <= 1'b1;
            sk_data  <= mem[rd_addr];
            sk_last  <= px_last;
            sk_user  <= px_user;
            sk_done  <= px_done;
            sk_bank  <= rd_bank_q;
        end
    end

endmodule

// File: tb/tb_raster_to_block.sv
// Testbench for raster_to_block (IMG_WIDTH=16): scoreboard of block-ordered
// expectations, checked at each output handshake, plus directed checks of
// latency, back-pressure, framing errors and reset.
module tb_raster_to_block;

    localparam int unsigned W  = 16;
    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          sync_err;

    int checks     = 0;
    int errors     = 0;
    int out_count  = 0;
    int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    logic [DW+1:0] sb_q[$];

    raster_to_block #(.IMG_WIDTH(W), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .sync_err      (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return {8'h00, 8'(r), 8'(c)};
    endfunction

    // Expected block-order output of one stripe whose first line is r0
    task automatic push_stripe(input int r0, input logic sof);
        for (int b = 0; b < int'(W / 8); b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    sb_q.push_back({pix(r0 + r, b * 8 + c), 1'(r == 7 && c == 7),
                                    1'(sof && b == 0 && r == 0 && c == 0)});
    endtask

    // Called at a negedge-aligned time; returns at the negedge after acceptance
    task automatic send_px(input logic [DW-1:0] d, input logic last, input logic user);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("send_timeout", 32'(s_axis_tready), 32'd1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // bad_last puts an extra tlast on column 9 of line 2
    task automatic send_stripe(input int r0, input logic sof, input logic bad_last);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < int'(W); c++)
                send_px(pix(r0 + r, c),
                        1'(c == int'(W) - 1 || (bad_last && r == 2 && c == 9)),
                        1'(sof && r == 0 && c == 0));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    // Downstream ready pattern, updated just after each rising edge
    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    // Output monitor: scoreboard compare on handshake, hold check on stall
    task automatic monitor_loop();
        logic          stall_seen = 1'b0;
        logic [DW+1:0] stall_val  = '0;
        logic [DW+1:0] obs;
        logic [DW+1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_seen = 1'b0;
            end else begin
                obs = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
                if (stall_seen) begin
                    checks++;
                    assert (m_axis_tvalid === 1'b1 && obs === stall_val) else begin
                        errors++;
                        $error("FAIL stall_hold obs=%b/%h exp=1/%h", m_axis_tvalid, obs, stall_val);
                    end
                end
                stall_seen = m_axis_tvalid && !m_axis_tready;
                stall_val  = obs;
                if (m_axis_tvalid && m_axis_tready) begin
                    checks++;
                    assert (sb_q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_out obs=%h exp=none", obs);
                    end
                    if (sb_q.size() != 0) begin
                        exp = sb_q.pop_front();
                        checks++;
                        assert (obs === exp) else begin
                            errors++;
                            $error("FAIL out_pixel[%0d] obs=%h exp=%h", out_count, obs, exp);
                        end
                    end
                    out_count++;
                end
            end
        end
    endtask

    initial begin
        int hs;
        int n;
        int base;

        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;
        fork
            ready_loop();
            monitor_loop();
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_s_tready", 32'(s_axis_tready), 32'd1);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
        check("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
        check("rst_m_tuser",  32'(m_axis_tuser),  32'd0);
        check("rst_sync_err", 32'(sync_err),      32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Stripe 0 with SOF, consumer always ready; first output latency
        ready_mode = 1;
        push_stripe(0, 1'b1);
        send_stripe(0, 1'b1, 1'b0);
        check("lat_e0", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        check("lat_e1", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        check("lat_e2", 32'(m_axis_tvalid), 32'd1);
        drain("drain_s0");
        check("count_s0", 32'(out_count), 32'd128);
        repeat (3) @(negedge clk);
        check("idle_after_s0", 32'(m_axis_tvalid), 32'd0);
        check("no_err_s0", 32'(sync_err), 32'd0);

        // Stripe 1, no SOF, random downstream stalls
        ready_mode = 2;
        push_stripe(8, 1'b0);
        send_stripe(8, 1'b0, 1'b0);
        drain("drain_s1");
        check("count_s1", 32'(out_count), 32'd256);

        // Two stripes with consumer blocked: both banks fill
        ready_mode = 0;
        repeat (2) @(negedge clk);
        push_stripe(16, 1'b0);
        push_stripe(24, 1'b0);
        send_stripe(16, 1'b0, 1'b0);
        check("tready_one_full", 32'(s_axis_tready), 32'd1);
        send_stripe(24, 1'b0, 1'b0);
        check("tready_both_full", 32'(s_axis_tready), 32'd0);
        repeat (5) @(negedge clk);
        check("tready_still_low", 32'(s_axis_tready), 32'd0);
        ready_mode = 1;
        hs = 0;
        n  = 0;
        while (hs < 128 && n < 2000) begin
            @(negedge clk);
            n++;
            if (m_axis_tvalid && m_axis_tready) hs++;
        end
        check("hs_count", 32'(hs), 32'd128);
        check("tready_at_last_hs", 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        check("tready_after_last_hs", 32'(s_axis_tready), 32'd1);
        drain("drain_s23");

        // Misplaced tlast: sticky error, data path unaffected
        ready_mode = 1;
        push_stripe(32, 1'b0);
        send_stripe(32, 1'b0, 1'b1);
        check("err_tlast", 32'(sync_err), 32'd1);
        drain("drain_s4");
        check("err_sticky", 32'(sync_err), 32'd1);

        // Reset in the middle of draining a stripe
        push_stripe(40, 1'b1);
        send_stripe(40, 1'b1, 1'b0);
        base = out_count;
        n = 0;
        while (out_count < base + 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_drain_progress", 32'(out_count >= base + 20), 32'd1);
        #1 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("mrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mrst_m_tdata",  32'(m_axis_tdata),  32'd0);
        check("mrst_m_tlast",  32'(m_axis_tlast),  32'd0);
        check("mrst_m_tuser",  32'(m_axis_tuser),  32'd0);
        check("mrst_sync_err", 32'(sync_err),      32'd0);
        check("mrst_s_tready", 32'(s_axis_tready), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(m_axis_tvalid), 32'd0);
        push_stripe(48, 1'b0);
        send_stripe(48, 1'b0, 1'b0);
        drain("drain_fresh");
        check("no_err_fresh", 32'(sync_err), 32'd0);

        // SOF at line 3, column 5: partial stripe discarded, restart at origin
        ready_mode = 2;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < int'(W); c++)
                send_px(pix(56 + r, c), 1'(c == int'(W) - 1), 1'b0);
        for (int c = 0; c < 5; c++)
            send_px(pix(59, c), 1'b0, 1'b0);
        check("no_err_partial", 32'(sync_err), 32'd0);
        push_stripe(64, 1'b1);
        send_px(pix(64, 0), 1'b0, 1'b1);
        check("err_sof", 32'(sync_err), 32'd1);
        for (int c = 1; c < int'(W); c++)
            send_px(pix(64, c), 1'(c == int'(W) - 1), 1'b0);
        for (int r = 1; r < 8; r++)
            for (int c = 0; c < int'(W); c++)
                send_px(pix(64 + r, c), 1'(c == int'(W) - 1), 1'b0);
        drain("drain_restart");
        check("err_sof_sticky", 32'(sync_err), 32'd1);
        repeat (4) @(negedge clk);
        check("final_idle", 32'(m_axis_tvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
